// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard_ctrl pipeline-control bus; HAZ_PERF_EN adds stall_cnt/flush_cnt
interface hazard_ctrl_if;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic [4:0] rdM;
    logic [4:0] rdW;
    logic       regwriteM;
    logic       regwriteW;
    logic       memtoregE;
    logic       pcsrcE;
    logic       mdstartE;
    logic [1:0] fwdaE;
    logic [1:0] fwdbE;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       mdbusy;
    logic       mdvalidE;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output regwriteM, regwriteW, memtoregE, pcsrcE, mdstartE,
        input  fwdaE, fwdbE, stallF, stallD, stallE,
        input  flushD, flushE, flushM, mdbusy, mdvalidE
`ifdef HAZ_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  regwriteM, regwriteW, memtoregE, pcsrcE, mdstartE,
        output fwdaE, fwdbE, stallF, stallD, stallE,
        output flushD, flushE, flushM, mdbusy, mdvalidE
`ifdef HAZ_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - xgriscv forwarding/stall/flush sequencer; HAZ_PERF_EN enables stall/flush counters
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] fwda, fwdb;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic       md_busy, md_valid;
    logic       load_use;

    // MEM result is younger than WB, so it wins when both match
    always_comb begin
        fwda = 2'b00;
        fwdb = 2'b00;
        if (bus.regwriteM && bus.rdM != 5'd0 && bus.rdM == bus.rs1E)
            fwda = 2'b10;
        else if (bus.regwriteW && bus.rdW != 5'd0 && bus.rdW == bus.rs1E)
            fwda = 2'b01;
        if (bus.regwriteM && bus.rdM != 5'd0 && bus.rdM == bus.rs2E)
            fwdb = 2'b10;
        else if (bus.regwriteW && bus.rdW != 5'd0 && bus.rdW == bus.rs2E)
            fwdb = 2'b01;
    end

    assign load_use = bus.memtoregE && bus.rdE != 5'd0 &&
                      (bus.rdE == bus.rs1D || bus.rdE == bus.rs2D);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        md_busy  = 1'b0;
        md_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.pcsrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (bus.mdstartE) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    md_busy = 1'b1;
                    state_d = BUSY;
                    cnt_d   = MD_INIT;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            BUSY: begin
                // pipeline is frozen here, so branch and load-use inputs are stale
                if (cnt_q != '0) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    md_busy = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    md_valid = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fwdaE    = fwda;
    assign bus.fwdbE    = fwdb;
    assign bus.stallF   = stall_f;
    assign bus.stallD   = stall_d;
    assign bus.stallE   = stall_e;
    assign bus.flushD   = flush_d;
    assign bus.flushE   = flush_e;
    assign bus.flushM   = flush_m;
    assign bus.mdbusy   = md_busy;
    assign bus.mdvalidE = md_valid;

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall_f);
        flush_cnt_d = flush_cnt_q + 32'(flush_e);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage xgriscv datapath.
- Generates EX-stage operand forwarding selects.
- Generates stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers: load-use bubbles, taken branch/jump flushes, and a fixed-latency multi-cycle EX operation (mul/div).
- Sits beside the controller; its outputs drive the enable and clear pins of the pcenr/floprc pipeline registers.

Parameters:
- MD_LAT, 32: stall cycles charged to a multi-cycle EX op (≥1).
- CNT_W, 6: latency counter width; MD_LAT ≤ 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs1D, rs2D  in  5  source register indices in ID.
- rs1E, rs2E  in  5  source register indices in EX.
- rdE, rdM, rdW  in  5  destination indices in EX/MEM/WB.
- regwriteM, regwriteW  in  1  register write enables in MEM/WB.
- memtoregE  in  1  EX instruction is a load.
- pcsrcE  in  1  taken branch/jump resolved in EX.
- mdstartE  in  1  EX instruction is a multi-cycle op (level, held while it sits in EX).
- fwdaE, fwdbE  out  2  forward select: 00 regfile, 01 WB result, 10 MEM aluout.
- stallF, stallD, stallE  out  1  hold PC / IF-ID / ID-EX registers.
- flushD, flushE, flushM  out  1  clear IF-ID / ID-EX / EX-MEM registers.
- mdbusy  out  1  multi-cycle op in progress.
- mdvalidE  out  1  one-cycle pulse: multi-cycle result valid for EX/MEM capture.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, cnt=0. All outputs 0 given zero inputs.
- Forwarding is combinational; applies to both rs1E and rs2E independently:
  - fwdaE=10 if regwriteM && rdM≠0 && rdM==rs1E;
  - else fwdaE=01 if regwriteW && rdW≠0 && rdW==rs1E;
  - else 00. MEM has priority over WB.
- Branch/jump: pcsrcE=1 → flushD=1, flushE=1 the same cycle; stalls 0.
  - pcsrcE overrides a load-use hazard.
  - pcsrcE overrides mdstartE; no MD op is started.
- Load-use, evaluated only in IDLE with pcsrcE=0 and mdstartE=0:
  - Condition: memtoregE && rdE≠0 && (rdE==rs1D || rdE==rs2D).
  - Response: stallF=stallD=1, flushE=1 for exactly one cycle. No registered state is needed.
- FSM states: IDLE, BUSY.
  - IDLE with mdstartE=1 and pcsrcE=0:
    - stallF=stallD=stallE=1, flushM=1, mdbusy=1.
    - Next state BUSY, cnt←MD_LAT−1.
    - If MD_LAT=1, next state is BUSY with cnt=0.
  - BUSY with cnt≠0: all three stalls=1, flushM=1, mdbusy=1, cnt←cnt−1.
  - BUSY with cnt==0:
    - Stalls=0, flushM=0, mdbusy=0, mdvalidE=1.
    - Next state IDLE. The MD instruction advances to MEM on this edge.
  - Total stall cycles per MD op = MD_LAT. The instruction occupies EX for MD_LAT+1 cycles.
- During BUSY, the load-use check and pcsrcE are ignored: the pipeline is frozen and the ID/EX contents cannot change.
- In IDLE, mdstartE seen on the cycle immediately after a BUSY→IDLE return belongs to the next instruction and starts a new sequence.
- Reset asserted mid-BUSY: immediate return to IDLE, cnt=0, no mdvalidE pulse.
- Counter arithmetic is unsigned CNT_W-bit and never decremented below 0.

Optional Feature:
- Macro: HAZ_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and wrapping modulo 2^32.
  - stall_cnt increments on every cycle with stallF=1.
  - flush_cnt increments on every cycle with flushE=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding:
  - rs1E=5, rdM=5, regwriteM=1, rdW=5, regwriteW=1 → fwdaE=10.
  - Same with rdM=0 → fwdaE=01.
  - rs2E=0 with a matching write → fwdbE=00.
- Load-use: memtoregE=1, rdE=7, rs2D=7 → stallF=stallD=flushE=1 for one cycle.
  - Same with rdE=0 → no stall.
- Branch: pcsrcE=1 coincident with load-use conditions → flushD=flushE=1, stallF=0.
- MD op, MD_LAT=4, mdstartE held high:
  - Stalls and flushM asserted for 4 cycles.
  - Then mdvalidE=1 with stalls=0 for 1 cycle.
  - Then IDLE; mdbusy high for exactly 4 cycles.
- Reset mid-operation: assert reset=0 two cycles into BUSY (MD_LAT=8) → outputs clear asynchronously with no mdvalidE.
  - After release with mdstartE=1, a fresh 8-cycle stall follows.
- HAZ_PERF_EN: one MD op (MD_LAT=4), one load-use and one branch.
  - stall_cnt=5, flush_cnt=2.
